// File: rtl/reservation_alu0_issue_ctrl_if.sv
// Bundle of dispatch, entry-side and execution-side signals for the ALU0
// reservation station issue controller. The controller uses the slave modport.
// The upstream/entry/execution environment uses the master modport.
interface reservation_alu0_issue_ctrl_if;
    logic         iFLUSH;
    logic         iDISP_VALID;
    logic         oDISP_FULL;
    logic [3:0]   oENTRY_REGIST_VALID;
    logic [3:0]   oENTRY_REGIST_POINTER;
    logic [3:0]   oEX_EXECUTION_POINTER;
    logic [3:0]   oENTRY_EXOUT_VALID;
    logic         oENTRY_REMOVE_VALID;
    logic [3:0]   iENTRY_VALID;
    logic [3:0]   iENTRY_MATCHING;
    logic [359:0] iENTRY_INFO;
    logic         oEX_VALID;
    logic [4:0]   oEX_CMD;
    logic [3:0]   oEX_CC;
    logic [4:0]   oEX_FLAG;
    logic [31:0]  oEX_SOURCE1;
    logic [31:0]  oEX_PC;
    logic [5:0]   oEX_DESTINATION_REGNAME;
    logic [5:0]   oEX_COMMIT_TAG;
    logic         iEX_BUSY;
    logic [31:0]  oPERF_ISSUE_COUNT;
    logic [31:0]  oPERF_STALL_COUNT;

    modport master (
        output iFLUSH, iDISP_VALID, iENTRY_VALID, iENTRY_MATCHING, iENTRY_INFO, iEX_BUSY,
        input  oDISP_FULL, oENTRY_REGIST_VALID, oENTRY_REGIST_POINTER, oEX_EXECUTION_POINTER,
               oENTRY_EXOUT_VALID, oENTRY_REMOVE_VALID, oEX_VALID, oEX_CMD, oEX_CC, oEX_FLAG,
               oEX_SOURCE1, oEX_PC, oEX_DESTINATION_REGNAME, oEX_COMMIT_TAG,
               oPERF_ISSUE_COUNT, oPERF_STALL_COUNT
    );

    modport slave (
        input  iFLUSH, iDISP_VALID, iENTRY_VALID, iENTRY_MATCHING, iENTRY_INFO, iEX_BUSY,
        output oDISP_FULL, oENTRY_REGIST_VALID, oENTRY_REGIST_POINTER, oEX_EXECUTION_POINTER,
               oENTRY_EXOUT_VALID, oENTRY_REMOVE_VALID, oEX_VALID, oEX_CMD, oEX_CC, oEX_FLAG,
               oEX_SOURCE1, oEX_PC, oEX_DESTINATION_REGNAME, oEX_COMMIT_TAG,
               oPERF_ISSUE_COUNT, oPERF_STALL_COUNT
    );
endinterface

// File: rtl/reservation_alu0_issue_ctrl.sv
// ALU0 reservation station control: allocates free entries to dispatched ops,
// keeps the registration/execution pointers, selects the ready entry and
// registers its payload into a one-deep output stage toward the ALU0 unit.
// Optional performance counters: MIST1032SA_RS_ALU0_PERF_COUNTER_EN.
module reservation_alu0_issue_ctrl (
    input  logic                                iCLOCK,
    input  logic                                inRESET,
    reservation_alu0_issue_ctrl_if.slave        bus
);

    logic [3:0]  rp;
    logic [3:0]  ep;
    logic        ex_valid;
    logic [89:0] ex_payload;

    logic [3:0]  sel_raw;
    logic [3:0]  free_onehot;
    logic [3:0]  sel_onehot;
    logic [89:0] sel_payload;
    logic        disp_full;
    logic        accept;
    logic        issue;

    // lowest-index free entry and lowest-index ready entry
    always_comb begin
        sel_raw     = bus.iENTRY_VALID & bus.iENTRY_MATCHING;
        free_onehot = '0;
        sel_onehot  = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (!bus.iENTRY_VALID[k[1:0]] && (free_onehot == '0)) free_onehot[k[1:0]] = 1'b1;
            if (sel_raw[k[1:0]] && (sel_onehot == '0))           sel_onehot[k[1:0]]  = 1'b1;
        end
    end

    // payload of the selected entry
    always_comb begin
        sel_payload = '0;
        case (1'b1)
            sel_onehot[0]: sel_payload = bus.iENTRY_INFO[89:0];
            sel_onehot[1]: sel_payload = bus.iENTRY_INFO[179:90];
            sel_onehot[2]: sel_payload = bus.iENTRY_INFO[269:180];
            sel_onehot[3]: sel_payload = bus.iENTRY_INFO[359:270];
            default:       sel_payload = '0;
        endcase
    end

    assign disp_full = &bus.iENTRY_VALID;
    assign accept    = bus.iDISP_VALID && !disp_full && !bus.iFLUSH;
    assign issue     = (sel_onehot != '0) && !bus.iFLUSH && (!ex_valid || !bus.iEX_BUSY);

    assign bus.oDISP_FULL            = disp_full;
    assign bus.oENTRY_REGIST_VALID   = accept ? free_onehot : '0;
    assign bus.oENTRY_REGIST_POINTER = rp;
    assign bus.oEX_EXECUTION_POINTER = ep;
    assign bus.oENTRY_EXOUT_VALID    = issue ? sel_onehot : '0;
    assign bus.oENTRY_REMOVE_VALID   = bus.iFLUSH;

    // pointers and output-stage valid; flush empties the station
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            rp       <= '0;
            ep       <= '0;
            ex_valid <= 1'b0;
        end else if (bus.iFLUSH) begin
            rp       <= '0;
            ep       <= '0;
            ex_valid <= 1'b0;
        end else begin
            if (accept) rp <= rp + 4'd1;
            if (issue) begin
                ep       <= ep + 4'd1;
                ex_valid <= 1'b1;
            end else if (!bus.iEX_BUSY) begin
                ex_valid <= 1'b0;
            end
        end
    end

    // output-stage payload, loaded only on issue so it holds while busy
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            ex_payload <= '0;
        end else if (issue) begin
            ex_payload <= sel_payload;
        end
    end

    assign bus.oEX_VALID               = ex_valid;
    assign bus.oEX_CMD                 = ex_payload[89:85];
    assign bus.oEX_CC                  = ex_payload[84:81];
    assign bus.oEX_FLAG                = ex_payload[80:76];
    assign bus.oEX_SOURCE1             = ex_payload[75:44];
    assign bus.oEX_PC                  = ex_payload[43:12];
    assign bus.oEX_DESTINATION_REGNAME = ex_payload[11:6];
    assign bus.oEX_COMMIT_TAG          = ex_payload[5:0];

`ifdef MIST1032SA_RS_ALU0_PERF_COUNTER_EN
    logic [31:0] issue_count;
    logic [31:0] stall_count;

    // issue count and busy-stall cycle count; only reset clears them
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            issue_count <= '0;
            stall_count <= '0;
        end else begin
            if (issue)                    issue_count <= issue_count + 32'd1;
            if (ex_valid && bus.iEX_BUSY) stall_count <= stall_count + 32'd1;
        end
    end

    assign bus.oPERF_ISSUE_COUNT = issue_count;
    assign bus.oPERF_STALL_COUNT = stall_count;
`else
    assign bus.oPERF_ISSUE_COUNT = '0;
    assign bus.oPERF_STALL_COUNT = '0;
`endif

endmodule

// File: tb/tb_reservation_alu0_issue_ctrl.sv
// Self-checking bench for reservation_alu0_issue_ctrl. The bench plays the
// four entry modules and compares the DUT with a reference model of the
// allocation/issue rules. Honours MIST1032SA_RS_ALU0_PERF_COUNTER_EN.
module tb_reservation_alu0_issue_ctrl;

    logic iCLOCK = 1'b0;
    logic inRESET;
    always #5 iCLOCK = ~iCLOCK;

    reservation_alu0_issue_ctrl_if bus ();

    reservation_alu0_issue_ctrl dut (
        .iCLOCK  (iCLOCK),
        .inRESET (inRESET),
        .bus     (bus)
    );

`ifdef MIST1032SA_RS_ALU0_PERF_COUNTER_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // stimulus / emulated entries
    logic        disp, flush, busy;
    logic [3:0]  ent_valid, ent_match;
    logic [89:0] ent_info [4];

    // reference model
    logic [3:0]  m_rp, m_ep;
    logic        m_exv;
    logic [89:0] m_pay;
    logic [31:0] m_issues, m_stalls;

    logic [89:0] ex_pay;
    assign ex_pay = {bus.oEX_CMD, bus.oEX_CC, bus.oEX_FLAG, bus.oEX_SOURCE1, bus.oEX_PC,
                     bus.oEX_DESTINATION_REGNAME, bus.oEX_COMMIT_TAG};

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [89:0] rand90();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[89:0];
    endfunction

    // dispatch accepted only with a free entry and no flush; lowest free entry wins
    function automatic logic [3:0] exp_regist();
        if (!disp || flush || ent_valid == 4'hF) return 4'h0;
        return 4'(1 << lowest(~ent_valid));
    endfunction

    // issue needs a ready entry, no flush, and room in the output stage
    function automatic logic [3:0] exp_exout();
        logic [3:0] s;
        s = ent_valid & ent_match;
        if (s == 4'h0 || flush || (m_exv && busy)) return 4'h0;
        return 4'(1 << lowest(s));
    endfunction

    task automatic model_reset();
        m_rp = 4'd0; m_ep = 4'd0; m_exv = 1'b0; m_pay = '0;
        m_issues = 32'd0; m_stalls = 32'd0;
        ent_valid = 4'h0; ent_match = 4'h0;
    endtask

    task automatic settle();
        bus.iDISP_VALID     = disp;
        bus.iFLUSH          = flush;
        bus.iEX_BUSY        = busy;
        bus.iENTRY_VALID    = ent_valid;
        bus.iENTRY_MATCHING = ent_match;
        bus.iENTRY_INFO     = {ent_info[3], ent_info[2], ent_info[1], ent_info[0]};
        #1;
    endtask

    // advance one clock: update the model and the emulated entries
    task automatic step();
        logic [3:0] r, x;
        int i;
        r = exp_regist();
        x = exp_exout();
        @(posedge iCLOCK);
        if (!inRESET) begin
            model_reset();
        end else begin
            if (m_exv && busy) m_stalls = m_stalls + 32'd1;
            if (flush) begin
                m_rp = 4'd0; m_ep = 4'd0; m_exv = 1'b0;
                ent_valid = 4'h0; ent_match = 4'h0;
            end else begin
                if (r != 4'h0) m_rp = m_rp + 4'd1;
                if (x != 4'h0) begin
                    i = lowest(x);
                    m_pay = ent_info[i]; m_exv = 1'b1; m_ep = m_ep + 4'd1;
                    m_issues = m_issues + 32'd1;
                    ent_valid[i] = 1'b0; ent_match[i] = 1'b0;
                end else if (!busy) begin
                    m_exv = 1'b0;
                end
                if (r != 4'h0) begin
                    i = lowest(r);
                    ent_valid[i] = 1'b1; ent_info[i] = rand90();
                end
            end
        end
        #1;
        settle();
    endtask

    task automatic test_reset();
        inRESET = 1'b0;
        disp = 0; flush = 0; busy = 0;
        for (int k = 0; k < 4; k++) ent_info[k] = rand90();
        model_reset();
        settle();
        n_checks++; if (bus.oEX_VALID !== 1'b0) begin n_errors++; $display("FAIL reset_ex_valid got=%b exp=0", bus.oEX_VALID); end
        n_checks++; if (bus.oEX_EXECUTION_POINTER !== 4'd0) begin n_errors++; $display("FAIL reset_ep got=%0d exp=0", bus.oEX_EXECUTION_POINTER); end
        n_checks++; if (bus.oENTRY_REGIST_POINTER !== 4'd0) begin n_errors++; $display("FAIL reset_rp got=%0d exp=0", bus.oENTRY_REGIST_POINTER); end
        n_checks++; if (ex_pay !== 90'd0) begin n_errors++; $display("FAIL reset_payload got=%h exp=0", ex_pay); end
        n_checks++; if (bus.oPERF_ISSUE_COUNT !== 32'd0 || bus.oPERF_STALL_COUNT !== 32'd0) begin n_errors++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", bus.oPERF_ISSUE_COUNT, bus.oPERF_STALL_COUNT); end
        repeat (2) @(posedge iCLOCK);
        @(negedge iCLOCK);
        inRESET = 1'b1;
        settle();
    endtask

    task automatic test_fill();
        disp = 1; settle();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus.oENTRY_REGIST_VALID !== 4'(1 << i)) begin n_errors++; $display("FAIL fill_regist[%0d] got=%b exp=%b", i, bus.oENTRY_REGIST_VALID, 4'(1 << i)); end
            n_checks++; if (bus.oENTRY_REGIST_POINTER !== 4'(i)) begin n_errors++; $display("FAIL fill_pointer[%0d] got=%0d exp=%0d", i, bus.oENTRY_REGIST_POINTER, i); end
            step();
        end
        n_checks++; if (bus.oDISP_FULL !== 1'b1) begin n_errors++; $display("FAIL fill_full got=%b exp=1", bus.oDISP_FULL); end
        n_checks++; if (bus.oENTRY_REGIST_VALID !== 4'h0) begin n_errors++; $display("FAIL fill_fifth got=%b exp=0000", bus.oENTRY_REGIST_VALID); end
        step();
        n_checks++; if (bus.oENTRY_REGIST_POINTER !== 4'd4) begin n_errors++; $display("FAIL fill_rp_hold got=%0d exp=4", bus.oENTRY_REGIST_POINTER); end
        disp = 0; settle();
    endtask

    task automatic test_issue();
        logic [89:0] p;
        logic [3:0]  e0;
        busy = 0; ent_match = 4'b0100; settle();
        p = ent_info[2]; e0 = m_ep;
        n_checks++; if (bus.oENTRY_EXOUT_VALID !== 4'b0100) begin n_errors++; $display("FAIL issue_exout got=%b exp=0100", bus.oENTRY_EXOUT_VALID); end
        step();
        n_checks++; if (bus.oEX_VALID !== 1'b1) begin n_errors++; $display("FAIL issue_valid got=%b exp=1", bus.oEX_VALID); end
        n_checks++; if (ex_pay !== p) begin n_errors++; $display("FAIL issue_payload got=%h exp=%h", ex_pay, p); end
        n_checks++; if (bus.oEX_EXECUTION_POINTER !== e0 + 4'd1) begin n_errors++; $display("FAIL issue_ep got=%0d exp=%0d", bus.oEX_EXECUTION_POINTER, e0 + 4'd1); end
        n_checks++; if (bus.oDISP_FULL !== 1'b0) begin n_errors++; $display("FAIL issue_freed got=%b exp=0", bus.oDISP_FULL); end
        step();
        n_checks++; if (bus.oEX_VALID !== 1'b0) begin n_errors++; $display("FAIL issue_drain got=%b exp=0", bus.oEX_VALID); end
    endtask

    task automatic test_stall();
        logic [89:0] p1;
        busy = 0; ent_match = 4'b0001; settle();
        step();
        busy = 1; ent_match[1] = 1'b1; settle();
        p1 = ent_info[1];
        for (int c = 0; c < 3; c++) begin
            n_checks++; if (bus.oENTRY_EXOUT_VALID !== 4'h0) begin n_errors++; $display("FAIL stall_exout[%0d] got=%b exp=0000", c, bus.oENTRY_EXOUT_VALID); end
            n_checks++; if (bus.oEX_VALID !== 1'b1 || ex_pay !== m_pay) begin n_errors++; $display("FAIL stall_hold[%0d] got=%b/%h exp=1/%h", c, bus.oEX_VALID, ex_pay, m_pay); end
            step();
        end
        n_checks++; if (bus.oPERF_STALL_COUNT !== (PERF ? m_stalls : 32'd0)) begin n_errors++; $display("FAIL stall_count got=%0d exp=%0d", bus.oPERF_STALL_COUNT, PERF ? m_stalls : 32'd0); end
        busy = 0; settle();
        n_checks++; if (bus.oENTRY_EXOUT_VALID !== 4'b0010) begin n_errors++; $display("FAIL stall_release got=%b exp=0010", bus.oENTRY_EXOUT_VALID); end
        step();
        n_checks++; if (ex_pay !== p1) begin n_errors++; $display("FAIL stall_next_payload got=%h exp=%h", ex_pay, p1); end
    endtask

    task automatic test_flush();
        disp = 1; flush = 1; busy = 0; ent_match = 4'b1000; settle();
        n_checks++; if (bus.oENTRY_REMOVE_VALID !== 1'b1) begin n_errors++; $display("FAIL flush_remove got=%b exp=1", bus.oENTRY_REMOVE_VALID); end
        n_checks++; if (bus.oENTRY_REGIST_VALID !== 4'h0 || bus.oENTRY_EXOUT_VALID !== 4'h0) begin n_errors++; $display("FAIL flush_strobes got=%b/%b exp=0000/0000", bus.oENTRY_REGIST_VALID, bus.oENTRY_EXOUT_VALID); end
        step();
        flush = 0; disp = 0; settle();
        n_checks++; if (bus.oEX_VALID !== 1'b0) begin n_errors++; $display("FAIL flush_ex_valid got=%b exp=0", bus.oEX_VALID); end
        n_checks++; if (bus.oEX_EXECUTION_POINTER !== 4'd0 || bus.oENTRY_REGIST_POINTER !== 4'd0) begin n_errors++; $display("FAIL flush_pointers got=%0d/%0d exp=0/0", bus.oEX_EXECUTION_POINTER, bus.oENTRY_REGIST_POINTER); end
        n_checks++; if (bus.oENTRY_REMOVE_VALID !== 1'b0) begin n_errors++; $display("FAIL flush_remove_off got=%b exp=0", bus.oENTRY_REMOVE_VALID); end
    endtask

    task automatic test_priority();
        logic [89:0] p1, p3;
        disp = 1; settle();
        repeat (4) step();
        ent_match = 4'b1010; settle();
        p1 = ent_info[1]; p3 = ent_info[3];
        n_checks++; if (bus.oENTRY_EXOUT_VALID !== 4'b0010) begin n_errors++; $display("FAIL prio_exout got=%b exp=0010", bus.oENTRY_EXOUT_VALID); end
        n_checks++; if (bus.oDISP_FULL !== 1'b1 || bus.oENTRY_REGIST_VALID !== 4'h0) begin n_errors++; $display("FAIL prio_full_reject got=%b/%b exp=1/0000", bus.oDISP_FULL, bus.oENTRY_REGIST_VALID); end
        disp = 0; settle();
        step();
        n_checks++; if (ex_pay !== p1) begin n_errors++; $display("FAIL prio_payload1 got=%h exp=%h", ex_pay, p1); end
        n_checks++; if (bus.oENTRY_EXOUT_VALID !== 4'b1000) begin n_errors++; $display("FAIL prio_exout2 got=%b exp=1000", bus.oENTRY_EXOUT_VALID); end
        step();
        n_checks++; if (ex_pay !== p3) begin n_errors++; $display("FAIL prio_payload3 got=%h exp=%h", ex_pay, p3); end
    endtask

    task automatic test_wrap();
        flush = 1; settle(); step();
        flush = 0; busy = 0; settle();
        while (m_rp != 4'd15) begin
            disp = 1; settle(); step();
            disp = 0; ent_match = 4'b0001; settle(); step();
        end
        disp = 1; settle();
        n_checks++; if (bus.oENTRY_REGIST_POINTER !== 4'd15 || bus.oENTRY_REGIST_VALID !== 4'b0001) begin n_errors++; $display("FAIL wrap_rp15 got=%0d/%b exp=15/0001", bus.oENTRY_REGIST_POINTER, bus.oENTRY_REGIST_VALID); end
        step();
        disp = 0; ent_match = 4'b0001; settle();
        n_checks++; if (bus.oENTRY_REGIST_POINTER !== 4'd0) begin n_errors++; $display("FAIL wrap_rp0 got=%0d exp=0", bus.oENTRY_REGIST_POINTER); end
        n_checks++; if (bus.oEX_EXECUTION_POINTER !== 4'd15 || bus.oENTRY_EXOUT_VALID !== 4'b0001) begin n_errors++; $display("FAIL wrap_ep15 got=%0d/%b exp=15/0001", bus.oEX_EXECUTION_POINTER, bus.oENTRY_EXOUT_VALID); end
        step();
        n_checks++; if (bus.oEX_EXECUTION_POINTER !== 4'd0 || bus.oEX_VALID !== 1'b1 || ex_pay !== m_pay) begin n_errors++; $display("FAIL wrap_ep0 got=%0d/%b/%h exp=0/1/%h", bus.oEX_EXECUTION_POINTER, bus.oEX_VALID, ex_pay, m_pay); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            disp      = 1'($urandom_range(0, 1));
            busy      = ($urandom_range(0, 2) == 0);
            flush     = ($urandom_range(0, 24) == 0);
            ent_match = 4'($urandom());
            settle();
            n_checks++; if (bus.oDISP_FULL !== (ent_valid == 4'hF)) begin n_errors++; $display("FAIL rnd_full[%0d] got=%b exp=%b", c, bus.oDISP_FULL, ent_valid == 4'hF); end
            n_checks++; if (bus.oENTRY_REGIST_VALID !== exp_regist()) begin n_errors++; $display("FAIL rnd_regist[%0d] got=%b exp=%b", c, bus.oENTRY_REGIST_VALID, exp_regist()); end
            n_checks++; if (bus.oENTRY_REGIST_POINTER !== m_rp) begin n_errors++; $display("FAIL rnd_rp[%0d] got=%0d exp=%0d", c, bus.oENTRY_REGIST_POINTER, m_rp); end
            n_checks++; if (bus.oENTRY_EXOUT_VALID !== exp_exout()) begin n_errors++; $display("FAIL rnd_exout[%0d] got=%b exp=%b", c, bus.oENTRY_EXOUT_VALID, exp_exout()); end
            n_checks++; if (bus.oENTRY_REMOVE_VALID !== flush) begin n_errors++; $display("FAIL rnd_remove[%0d] got=%b exp=%b", c, bus.oENTRY_REMOVE_VALID, flush); end
            n_checks++; if (bus.oEX_VALID !== m_exv) begin n_errors++; $display("FAIL rnd_ex_valid[%0d] got=%b exp=%b", c, bus.oEX_VALID, m_exv); end
            n_checks++; if (bus.oEX_EXECUTION_POINTER !== m_ep) begin n_errors++; $display("FAIL rnd_ep[%0d] got=%0d exp=%0d", c, bus.oEX_EXECUTION_POINTER, m_ep); end
            if (m_exv) begin
                n_checks++; if (ex_pay !== m_pay) begin n_errors++; $display("FAIL rnd_payload[%0d] got=%h exp=%h", c, ex_pay, m_pay); end
            end
            n_checks++; if (bus.oPERF_ISSUE_COUNT !== (PERF ? m_issues : 32'd0)) begin n_errors++; $display("FAIL rnd_issue_count[%0d] got=%0d exp=%0d", c, bus.oPERF_ISSUE_COUNT, PERF ? m_issues : 32'd0); end
            n_checks++; if (bus.oPERF_STALL_COUNT !== (PERF ? m_stalls : 32'd0)) begin n_errors++; $display("FAIL rnd_stall_count[%0d] got=%0d exp=%0d", c, bus.oPERF_STALL_COUNT, PERF ? m_stalls : 32'd0); end
            step();
        end
        flush = 0; disp = 0; busy = 0; ent_match = 4'h0; settle();
    endtask

    task automatic test_async_reset();
        flush = 1; settle(); step();
        flush = 0; disp = 1; settle(); step();
        disp = 0; ent_match = 4'b0001; settle(); step();
        busy = 1; settle();
        n_checks++; if (bus.oEX_VALID !== 1'b1) begin n_errors++; $display("FAIL areset_pre got=%b exp=1", bus.oEX_VALID); end
        #2 inRESET = 1'b0;
        #1;
        n_checks++; if (bus.oEX_VALID !== 1'b0 || bus.oEX_EXECUTION_POINTER !== 4'd0 || bus.oENTRY_REGIST_POINTER !== 4'd0) begin n_errors++; $display("FAIL areset_drop got=%b/%0d/%0d exp=0/0/0", bus.oEX_VALID, bus.oEX_EXECUTION_POINTER, bus.oENTRY_REGIST_POINTER); end
        model_reset();
        busy = 0;
        @(negedge iCLOCK);
        inRESET = 1'b1;
        settle();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_issue();
        test_stall();
        test_flush();
        test_priority();
        test_wrap();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
